mdu_unit: RTL and testbench
===========================

# mdu_unit

Iterative multiply/divide unit with HI/LO registers, parametrised in operand width. It decodes R-type `funct` alongside the ALU decoder and serves mult/multu/div/divu/mfhi/mflo/mthi/mtlo. It runs multi-cycle operations behind a busy/stall handshake, so the CPU can freeze while the main ALU path keeps its single-cycle behaviour.

## Interface
Parameters:
- `WIDTH`, 32: operand, HI and LO width; must be ≥ 4.

Ports:
- `clk`, in, 1: rising-edge clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `start`, in, 1: instruction valid this cycle.
- `ALUop`, in, 2: MDU acts only when `2'b10`.
- `funct`, in, 6: R-type function field.
- `a`, in, WIDTH: rs operand (dividend / multiplicand / mthi-mtlo source).
- `b`, in, WIDTH: rt operand (divisor / multiplier).
- `result`, out, WIDTH: combinational; `hi` for mfhi, `lo` for mflo, else 0.
- `hi`, out, WIDTH: HI register.
- `lo`, out, WIDTH: LO register.
- `busy`, out, 1: operation in flight.
- `done`, out, 1: one-cycle pulse when HI/LO take a new mult/div result.
- `stall`, out, 1: combinational; `busy & start & (ALUop==2'b10) & funct is any MDU code`.
- `unsupported`, out, 1: combinational; see Configuration.

## Operation
- Funct codes:
  - `011000` mult
  - `011001` multu
  - `011010` div
  - `011011` divu
  - `010000` mfhi
  - `010001` mthi
  - `010010` mflo
  - `010011` mtlo
- All other funct codes, and any `ALUop != 2'b10`, are ignored with no state change.
- FSM states: IDLE, RUN, FIX.
  - IDLE→RUN on accepted mult/div: `start`, `ALUop==10`, MDU funct, state IDLE. The accepting edge latches operand magnitudes, the sign flags, the op, and `count=0`.
  - RUN: one iteration per cycle, shift-add multiply or restoring divide. Goes to FIX after `count==WIDTH-1`.
  - FIX: applies signs, writes HI/LO, asserts `done`, returns to IDLE.
- Multiply: `{HI,LO}` = full 2·WIDTH product. Signed for mult, unsigned for multu.
- Divide: LO = quotient, HI = remainder. Signed division truncates toward zero; the remainder takes the sign of the dividend.
- Divide by zero (div and divu): HI = `a`, LO = all ones. Full latency still applies.
- Signed overflow (most-negative / −1): LO = most-negative, HI = 0.
- mthi/mtlo in IDLE: HI (resp. LO) ← `a` at the next edge. No busy, no done.
- While busy, mthi/mtlo and new mult/div are dropped and `stall` is high. The CPU must hold the instruction until `stall` falls.
- mfhi/mflo while busy: `stall` high; `result` shows the old HI/LO.

## Timing
- Reset: state IDLE, `hi=0`, `lo=0`, `busy=0`, `done=0`, count 0.
- Reset mid-operation aborts the operation: HI/LO go to 0 and no `done` is produced.
- Accept edge E0. `busy` is high from E0 through E(WIDTH+1).
- HI/LO update and `done` rises at E(WIDTH+1); `busy` falls at the same edge. Latency is WIDTH+1 cycles.
- IDLE during the `done` cycle: a new start is accepted on that cycle (back-to-back). mfhi in that cycle returns the new result.
- `result`, `stall` and `unsupported` are combinational from inputs and state.
- `busy`, `done`, `hi` and `lo` are registered.

## Configuration
- `MDU_DIV_EN` defined: div/divu implemented as above; `unsupported` is tied 0.
- `MDU_DIV_EN` undefined: no divider datapath.
  - div/divu are not accepted: no state change, no `busy`.
  - `unsupported` is high whenever `start & ALUop==10 & funct∈{div,divu}`.
  - Multiply and move ops are unchanged.

## Structure
- Package `mdu_pkg` holds the funct localparams (`F_MULT`…`F_MTLO`), the state enum (IDLE/RUN/FIX) and the op enum (MUL, MULU, DIV, DIVU).
- Sub-module `mdu_iter_step`: combinational single-iteration datapath, shift-add or restoring-subtract.
- The top level holds the FSM, counter, sign handling and HI/LO registers.

## Test plan
All with WIDTH=32.
- mult, a=7, b=−3 (0xFFFFFFFD) → `done` 33 cycles after accept; HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- multu, a=0xFFFFFFFF, b=2 → HI=0x00000001, LO=0xFFFFFFFE.
- div, a=−7, b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu, a=5, b=0 → LO=0xFFFFFFFF, HI=5; without `MDU_DIV_EN` → `unsupported`=1, `busy` stays 0, HI/LO unchanged.
- mthi a=0x12345678 then mult started; mfhi issued while busy → `stall`=1 and `result`=0x12345678; mthi issued while busy is dropped.
- Reset asserted at cycle 10 of a multu → `busy`=0, HI=LO=0 immediately, and no `done` pulse ever follows.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared decode constants and enums for the iterative multiply/divide unit.
package mdu_pkg;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    localparam logic [1:0] ALUOP_MDU = 2'b10;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;
    typedef enum logic [1:0] {MUL, MULU, DIV, DIVU} op_e;

    function automatic logic is_mdu_funct(input logic [5:0] f);
        return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV)  || (f == F_DIVU) ||
               (f == F_MFHI) || (f == F_MTHI)  || (f == F_MFLO) || (f == F_MTLO);
    endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One iteration of the MDU datapath: shift-add multiply or restoring divide.
// The divide branch exists only when MDU_DIV_EN is defined.
module mdu_iter_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             div_i,
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] opnd_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] sum;

`ifdef MDU_DIV_EN
    logic [WIDTH:0] shifted;
`else
    logic unused_div;
    assign unused_div = div_i;
`endif

    always_comb begin
        // Multiply: {rem,quo} holds {partial product, remaining multiplier bits}.
        sum   = {1'b0, rem_i} + {1'b0, (quo_i[0] ? opnd_i : {WIDTH{1'b0}})};
        rem_o = sum[WIDTH:1];
        quo_o = {sum[0], quo_i[WIDTH-1:1]};
`ifdef MDU_DIV_EN
        shifted = {rem_i, quo_i[WIDTH-1]};
        if (div_i) begin
            if (shifted >= {1'b0, opnd_i}) begin
                rem_o = WIDTH'(shifted - {1'b0, opnd_i});
                quo_o = {quo_i[WIDTH-2:0], 1'b1};
            end else begin
                rem_o = shifted[WIDTH-1:0];
                quo_o = {quo_i[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

endmodule

// File: rtl/mdu_unit.sv
// Iterative multiply/divide unit with HI/LO registers and a busy/stall handshake.
// Divider datapath is present only when MDU_DIV_EN is defined.
//
// state | meaning
// IDLE  | ready; accepts mult/div and mthi/mtlo
// RUN   | one multiply/divide iteration per cycle
// FIX   | apply signs, write HI/LO, pulse done
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       ALUop,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic             unsupported
);

    localparam int CW = $clog2(WIDTH);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, opnd_q, opnd_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             neg_q, neg_d, neg_rem_q, neg_rem_d, div0_q, div0_d;
    logic             done_q, done_d;

    logic             mdu_sel, is_mul, is_div, div_ok, accept, signed_op, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag, step_rem, step_quo, quo_fix, rem_fix;
    logic [2*WIDTH-1:0] prod_fix;

    assign mdu_sel   = start && (ALUop == ALUOP_MDU);
    assign is_mul    = (funct == F_MULT) || (funct == F_MULTU);
    assign is_div    = (funct == F_DIV) || (funct == F_DIVU);
    assign signed_op = (funct == F_MULT) || (funct == F_DIV);
    assign a_neg     = signed_op && a[WIDTH-1];
    assign b_neg     = signed_op && b[WIDTH-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;

`ifdef MDU_DIV_EN
    assign div_ok      = is_div;
    assign unsupported = 1'b0;
`else
    assign div_ok      = 1'b0;
    assign unsupported = mdu_sel && is_div;
`endif

    assign accept = mdu_sel && (state_q == IDLE) && (is_mul || div_ok);

    mdu_iter_step #(.WIDTH(WIDTH)) u_step (
        .div_i  ((op_q == DIV) || (op_q == DIVU)),
        .rem_i  (rem_q),
        .quo_i  (quo_q),
        .opnd_i (opnd_q),
        .rem_o  (step_rem),
        .quo_o  (step_quo)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        count_d   = count_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        opnd_d    = opnd_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        prod_fix = neg_q ? -{rem_q, quo_q} : {rem_q, quo_q};
        quo_fix  = neg_q ? -quo_q : quo_q;
        rem_fix  = neg_rem_q ? -rem_q : rem_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = RUN;
                    count_d   = '0;
                    rem_d     = '0;
                    quo_d     = is_mul ? b_mag : a_mag;
                    opnd_d    = is_mul ? a_mag : b_mag;
                    neg_d     = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    div0_d    = is_div && (b == '0);
                    case (funct)
                        F_MULT:  op_d = MUL;
                        F_MULTU: op_d = MULU;
                        F_DIV:   op_d = DIV;
                        default: op_d = DIVU;
                    endcase
                end else if (mdu_sel && (funct == F_MTHI)) begin
                    hi_d = a;
                end else if (mdu_sel && (funct == F_MTLO)) begin
                    lo_d = a;
                end
            end
            RUN: begin
                rem_d   = step_rem;
                quo_d   = step_quo;
                count_d = count_q + 1'b1;
                if (count_q == CW'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if ((op_q == MUL) || (op_q == MULU)) begin
                    {hi_d, lo_d} = prod_fix;
                end else begin
                    // A zero divisor leaves |a| in the remainder, so the sign fix restores a.
                    hi_d = rem_fix;
                    lo_d = div0_q ? {WIDTH{1'b1}} : quo_fix;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= MUL;
            count_q   <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            opnd_q    <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            count_q   <= count_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            opnd_q    <= opnd_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign hi    = hi_q;
    assign lo    = lo_q;
    assign busy  = (state_q != IDLE);
    assign done  = done_q;
    assign stall = busy && mdu_sel && is_mdu_funct(funct);

    always_comb begin
        result = '0;
        if (ALUop == ALUOP_MDU) begin
            if (funct == F_MFHI)      result = hi_q;
            else if (funct == F_MFLO) result = lo_q;
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: stimulus pushes expected HI/LO, a monitor checks them on done.
module tb_mdu_unit;
    import mdu_pkg::*;

    localparam int W = 32;
`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   ALUop = 2'b00;
    logic [5:0]   funct = 6'b0;
    logic [W-1:0] a = '0, b = '0;
    logic [W-1:0] result, hi, lo;
    logic         busy, done, stall, unsupported;

    mdu_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ALUop(ALUop), .funct(funct),
        .a(a), .b(b), .result(result), .hi(hi), .lo(lo), .busy(busy),
        .done(done), .stall(stall), .unsupported(unsupported)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int unsigned  cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_pass = 0, n_total = 0, done_cnt = 0;
    int unsigned cyc = 0, busy_until = 0;
    logic [W-1:0] old_hi = '0, old_lo = '0, pend_hi = '0, pend_lo = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic logic [W-1:0] cur_hi();
        return (cyc >= busy_until) ? pend_hi : old_hi;
    endfunction

    function automatic logic [W-1:0] cur_lo();
        return (cyc >= busy_until) ? pend_lo : old_lo;
    endfunction

    // Architectural reference: {HI, LO} for a mult/div using plain arithmetic.
    function automatic logic [63:0] ref_op(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
        longint      sp;
        logic [63:0] up;
        int          sq, sr;
        case (f)
            F_MULT: begin
                sp = longint'($signed(x)) * longint'($signed(y));
                return sp;
            end
            F_MULTU: begin
                up = {32'b0, x} * {32'b0, y};
                return up;
            end
            F_DIV: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                sq = int'($signed(x)) / int'($signed(y));
                sr = int'($signed(x)) % int'($signed(y));
                return {sr, sq};
            end
            default: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("sb_hi", hi, mon_e.hi);
                check("sb_lo", lo, mon_e.lo);
                check("latency", cyc, mon_e.cyc);
            end
        end
    end

    task automatic issue(input logic [1:0] alu, input logic [5:0] f, input logic [W-1:0] av, input logic [W-1:0] bv);
        logic        bsy, mdu, ismul, isdiv, acc;
        logic [W-1:0] exp_res;
        logic [63:0] r;
        exp_t        e;
        @(negedge clk);
        start = 1'b1; ALUop = alu; funct = f; a = av; b = bv;
        #1;
        bsy   = (cyc < busy_until);
        mdu   = (alu == 2'b10) && (f inside {F_MULT, F_MULTU, F_DIV, F_DIVU, F_MFHI, F_MTHI, F_MFLO, F_MTLO});
        ismul = (alu == 2'b10) && (f inside {F_MULT, F_MULTU});
        isdiv = (alu == 2'b10) && (f inside {F_DIV, F_DIVU});
        exp_res = '0;
        if (alu == 2'b10 && f == F_MFHI) exp_res = cur_hi();
        if (alu == 2'b10 && f == F_MFLO) exp_res = cur_lo();
        check("stall", stall, bsy && mdu);
        check("unsupported", unsupported, isdiv && !DIV_EN);
        check("result", result, exp_res);
        acc = !bsy && (ismul || (isdiv && DIV_EN));
        @(posedge clk);
        #1;
        start = 1'b0; ALUop = 2'b00; funct = 6'b0;
        if (acc) begin
            r = ref_op(f, av, bv);
            old_hi = pend_hi; old_lo = pend_lo;
            pend_hi = r[63:32]; pend_lo = r[31:0];
            busy_until = cyc + W + 1;
            e.hi = r[63:32]; e.lo = r[31:0]; e.cyc = busy_until;
            sb.push_back(e);
        end else if (!bsy && alu == 2'b10 && f == F_MTHI) begin
            old_hi = av; pend_hi = av;
        end else if (!bsy && alu == 2'b10 && f == F_MTLO) begin
            old_lo = av; pend_lo = av;
        end
        check("busy", busy, cyc < busy_until);
        check("hi", hi, cur_hi());
        check("lo", lo, cur_lo());
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (!busy) return;
            @(negedge clk);
        end
        check("idle_timeout", busy, 0);
    endtask

    task automatic wait_done_cycle();
        for (int i = 0; i < 200 && cyc < busy_until; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 6))
            0: return '0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return W'($urandom_range(0, 20));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        logic [5:0] ftab [0:8];
        int         dsave;
        int         k;
        ftab = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MFHI, F_MTHI, F_MFLO, F_MTLO, 6'b100000};

        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        issue(2'b10, F_MULT, 32'd7, 32'hFFFF_FFFD);
        wait_idle();
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFEB);

        issue(2'b10, F_MULTU, 32'hFFFF_FFFF, 32'd2);
        wait_idle();
        check("multu_hi", hi, 32'h0000_0001);
        check("multu_lo", lo, 32'hFFFF_FFFE);

        issue(2'b10, F_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_idle();
`ifdef MDU_DIV_EN
        check("div_hi", hi, 32'hFFFF_FFFF);
        check("div_lo", lo, 32'hFFFF_FFFD);
`endif
        issue(2'b10, F_DIVU, 32'd5, 32'd0);
        wait_idle();
`ifdef MDU_DIV_EN
        check("divu0_hi", hi, 32'd5);
        check("divu0_lo", lo, 32'hFFFF_FFFF);
`endif

        issue(2'b10, F_MTHI, 32'h1234_5678, 32'd0);
        check("mthi_val", hi, 32'h1234_5678);
        issue(2'b10, F_MTLO, 32'hCAFE_0001, 32'd0);
        issue(2'b10, F_MULT, 32'd3, 32'd5);
        issue(2'b10, F_MFHI, 32'd0, 32'd0);
        issue(2'b10, F_MTHI, 32'hDEAD_BEEF, 32'd0);
        check("mthi_dropped", hi, 32'h1234_5678);
        wait_idle();

        // Back-to-back: mfhi then a new mult in the done cycle.
        issue(2'b10, F_MULTU, 32'hABCD_0123, 32'h0000_1000);
        wait_done_cycle();
        issue(2'b10, F_MFHI, 32'd0, 32'd0);
        issue(2'b10, F_MULT, 32'h8000_0000, 32'h8000_0000);
        wait_done_cycle();
        issue(2'b10, F_MULT, 32'hFFFF_FFFF, 32'd9);
        wait_idle();

        issue(2'b00, F_MTHI, 32'h5555_5555, 32'd0);
        issue(2'b10, 6'b100000, 32'h6666_6666, 32'd3);
        issue(2'b01, F_MULT, 32'd4, 32'd4);

        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 9);
            if (k == 9) issue(2'b00, F_MULT, pick(), pick());
            else issue(2'b10, ftab[k], pick(), pick());
            if ($urandom_range(0, 2) == 0) wait_idle();
        end
        wait_idle();

        issue(2'b10, F_MULTU, $urandom(), $urandom());
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        sb.delete();
        old_hi = '0; old_lo = '0; pend_hi = '0; pend_lo = '0; busy_until = 0;
        dsave = done_cnt;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (45) @(negedge clk);
        check("abort_no_done", done_cnt, dsave);
        check("abort_busy_later", busy, 0);

        issue(2'b10, F_MFLO, 32'd0, 32'd0);
        check("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
